// File: rtl/sha_pkg.sv
// sha_pkg: types and constants shared by the SHA-256 feeder and round stages
package sha_pkg;
    typedef logic [7:0][31:0] HashState;
    typedef logic [15:0][31:0] sha_block_t;
    typedef logic [2:0][31:0] sha_tail_t;
    typedef enum logic {IDLE, RUN} feeder_state_t;
    localparam logic [31:0] SHA_PAD_WORD = 32'h80000000;
    localparam int SHA_HDR_LEN_BITS = 640;
endpackage

// File: rtl/sha_header_pad.sv
// sha_header_pad: builds the padded second header block from tail words and nonce
module sha_header_pad
    import sha_pkg::*;
#(
    parameter int NONCE_IDX = 3,
    parameter int MSG_BITS  = SHA_HDR_LEN_BITS
) (
    input  sha_tail_t   tail,
    input  logic [31:0] nonce,
    output sha_block_t  blk
);
    always_comb begin
        blk            = '0;
        blk[0]         = tail[0];
        blk[1]         = tail[1];
        blk[2]         = tail[2];
        blk[4]         = SHA_PAD_WORD;
        blk[15]        = 32'(MSG_BITS);
        blk[NONCE_IDX] = nonce;
    end
endmodule

// File: rtl/sha_pipelined_nonce_feeder.sv
// sha_pipelined_nonce_feeder: accepts a mining job and issues one padded block per enabled cycle
module sha_pipelined_nonce_feeder
    import sha_pkg::*;
#(
    parameter int NONCE_IDX = 3,
    parameter int MSG_BITS  = SHA_HDR_LEN_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid_i,
    output logic        job_ready_o,
    input  HashState    midstate_i,
    input  sha_tail_t   tail_i,
    input  logic [31:0] nonce_start_i,
    input  logic [31:0] nonce_end_i,
    input  logic        enable_i,
    input  logic        abort_i,
    output HashState    state_o,
    output sha_block_t  W_o,
    output logic [31:0] nonce_o,
    output logic        valid_o,
    output logic        newblock_o,
    output logic        done_o
);
    feeder_state_t state, state_n;
    HashState      mid;
    sha_tail_t     tail;
    logic [31:0]   cur, last;
    logic          pending_new, accept, issue, is_last;
    sha_block_t    blk;

    assign job_ready_o = state == IDLE;

    always_comb begin
        accept  = state == IDLE && job_valid_i;
        issue   = state == RUN && !abort_i && enable_i;
        is_last = cur == last;
        state_n = accept ? RUN :
                  (state == RUN && (abort_i || (issue && is_last))) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    sha_header_pad #(.NONCE_IDX(NONCE_IDX), .MSG_BITS(MSG_BITS)) u_pad (
        .tail (tail),
        .nonce(cur),
        .blk  (blk)
    );

    // Output data registers only load on issue so they hold through pauses and bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid         <= '0;
            tail        <= '0;
            cur         <= '0;
            last        <= '0;
            pending_new <= 1'b0;
            state_o     <= '0;
            W_o         <= '0;
            nonce_o     <= '0;
            valid_o     <= 1'b0;
            newblock_o  <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            valid_o    <= issue;
            newblock_o <= issue && pending_new;
            done_o     <= issue && is_last;
            if (accept) begin
                mid         <= midstate_i;
                tail        <= tail_i;
                cur         <= nonce_start_i;
                last        <= nonce_end_i;
                pending_new <= 1'b1;
            end else if (state == RUN && abort_i) begin
                pending_new <= 1'b0;
            end else if (issue) begin
                state_o     <= mid;
                W_o         <= blk;
                nonce_o     <= cur;
                pending_new <= 1'b0;
                cur         <= cur + 32'd1;
            end
        end
    end
endmodule
